// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory slave: widths, command layout and
// the transaction controller state encoding plus its 3-bit LED code.
package spi_pkg;

    localparam int ADDR_WIDTH_DEF = 7;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int RW_BIT         = 0;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_GET_ADDR    = 4'd1,
        ST_ADDR        = 4'd2,
        ST_READ_WAIT   = 4'd3,
        ST_READ_LOAD   = 4'd4,
        ST_READ_SHIFT  = 4'd5,
        ST_WRITE_SHIFT = 4'd6,
        ST_WRITE_MEM   = 4'd7,
        ST_DONE        = 4'd8
    } state_t;

    // Nine states on three LEDs: the two single-cycle read setup states share code 3.
    function automatic logic [2:0] state_led(input state_t s);
        logic [2:0] code;
        code = 3'd0;
        case (s)
            ST_IDLE:        code = 3'd0;
            ST_GET_ADDR:    code = 3'd1;
            ST_ADDR:        code = 3'd2;
            ST_READ_WAIT:   code = 3'd3;
            ST_READ_LOAD:   code = 3'd3;
            ST_READ_SHIFT:  code = 3'd4;
            ST_WRITE_SHIFT: code = 3'd5;
            ST_WRITE_MEM:   code = 3'd6;
            ST_DONE:        code = 3'd7;
            default:        code = 3'd0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Per-byte SCLK bit counter, 0..DATA_WIDTH. done marks the increment that
// brings the count to DATA_WIDTH so the caller can react on that same edge.
module spi_bit_counter
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (inc && (r_count != CW'(DATA_WIDTH))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign done = inc && (r_count == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/spi_txn_controller.sv
// SPI memory slave transaction sequencer: command/address capture, read load,
// write commit and CS abort. Define SPI_BURST_EN for address auto-increment.
module spi_txn_controller
    import spi_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_cond,
    input  logic                  sclk_rise,
    input  logic [DATA_WIDTH-1:0] sr_data,
    output logic                  sr_we,
    output logic                  addr_we,
    output logic                  dm_we,
    output logic [ADDR_WIDTH-1:0] dm_addr,
    output logic                  miso_bufe,
    output logic                  txn_done,
    output logic [2:0]            state_dbg
);

    state_t                r_state;
    state_t                w_next;
    logic                  r_cs_prev;
    logic                  r_sr_we;
    logic                  r_addr_we;
    logic                  r_dm_we;
    logic                  r_miso_bufe;
    logic                  r_txn_done;
    logic [ADDR_WIDTH-1:0] r_dm_addr;
    logic                  w_shift_state;
    logic                  w_cnt_inc;
    logic                  w_cnt_clear;
    logic                  w_byte_done;

    assign w_shift_state = (r_state == ST_GET_ADDR) || (r_state == ST_READ_SHIFT) ||
                           (r_state == ST_WRITE_SHIFT);
    assign w_cnt_inc     = w_shift_state && sclk_rise;
    assign w_cnt_clear   = (w_next != r_state);

    spi_bit_counter #(.DATA_WIDTH(DATA_WIDTH)) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (w_cnt_clear),
        .inc   (w_cnt_inc),
        .done  (w_byte_done)
    );

    // CS high outranks every other condition, so a partial byte never reaches WRITE_MEM.
    always_comb begin
        w_next = r_state;
        if ((r_state != ST_IDLE) && cs_cond) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:        if (!cs_cond && r_cs_prev) w_next = ST_GET_ADDR;
                ST_GET_ADDR:    if (w_byte_done) w_next = ST_ADDR;
                ST_ADDR:        w_next = sr_data[RW_BIT] ? ST_READ_WAIT : ST_WRITE_SHIFT;
                ST_READ_WAIT:   w_next = ST_READ_LOAD;
                ST_READ_LOAD:   w_next = ST_READ_SHIFT;
`ifdef SPI_BURST_EN
                ST_READ_SHIFT:  if (w_byte_done) w_next = ST_READ_WAIT;
                ST_WRITE_MEM:   w_next = ST_WRITE_SHIFT;
`else
                ST_READ_SHIFT:  if (w_byte_done) w_next = ST_DONE;
                ST_WRITE_MEM:   w_next = ST_DONE;
`endif
                ST_WRITE_SHIFT: if (w_byte_done) w_next = ST_WRITE_MEM;
                ST_DONE:        w_next = ST_DONE;
                default:        w_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so each pulse lines up with its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cs_prev   <= 1'b0;
            r_sr_we     <= 1'b0;
            r_addr_we   <= 1'b0;
            r_dm_we     <= 1'b0;
            r_miso_bufe <= 1'b0;
            r_txn_done  <= 1'b0;
            r_dm_addr   <= '0;
        end else begin
            r_state     <= w_next;
            r_cs_prev   <= cs_cond;
            r_addr_we   <= (w_next == ST_ADDR);
            r_sr_we     <= (w_next == ST_READ_LOAD);
            r_dm_we     <= (w_next == ST_WRITE_MEM);
            r_miso_bufe <= (w_next == ST_READ_SHIFT);
            r_txn_done  <= (w_next == ST_WRITE_MEM) ||
                           ((r_state == ST_READ_SHIFT) && w_byte_done && !cs_cond);
            if (r_state == ST_ADDR) begin
                r_dm_addr <= sr_data[DATA_WIDTH-1 -: ADDR_WIDTH];
            end
`ifdef SPI_BURST_EN
            else if (((r_state == ST_READ_SHIFT) && (w_next == ST_READ_WAIT)) ||
                     ((r_state == ST_WRITE_MEM) && (w_next == ST_WRITE_SHIFT))) begin
                r_dm_addr <= r_dm_addr + 1'b1;
            end
`endif
        end
    end

    assign sr_we     = r_sr_we;
    assign addr_we   = r_addr_we;
    assign dm_we     = r_dm_we;
    assign dm_addr   = r_dm_addr;
    assign miso_bufe = r_miso_bufe;
    assign txn_done  = r_txn_done;
    assign state_dbg = state_led(r_state);

endmodule

// File: tb/tb_spi_txn_controller.sv
// Bench for spi_txn_controller: SPI master tasks, shift register and memory
// environment, reference memory and a write scoreboard.
module tb_spi_txn_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs_cond;
    logic       sclk_rise;
    logic       mosi;
    logic       mem_init;
    logic [7:0] sr_data;
    logic       sr_we, addr_we, dm_we, miso_bufe, txn_done;
    logic [6:0] dm_addr;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    spi_txn_controller dut (
        .clk       (clk),
        .reset     (reset),
        .cs_cond   (cs_cond),
        .sclk_rise (sclk_rise),
        .sr_data   (sr_data),
        .sr_we     (sr_we),
        .addr_we   (addr_we),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .miso_bufe (miso_bufe),
        .txn_done  (txn_done),
        .state_dbg (state_dbg)
    );

    // environment: shift register and synchronous data memory
    logic [7:0] mem [0:127];
    logic [7:0] mem_q;
    logic [7:0] tb_sr;
    assign sr_data = tb_sr;

    function automatic logic [7:0] init_val(input int i);
        return (i == 5) ? 8'hA5 : 8'((i * 37) + 11);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
            tb_sr <= 8'h00;
        end else begin
            mem_q <= mem[dm_addr];
            if (dm_we) mem[dm_addr] <= tb_sr;
            if (sr_we) tb_sr <= mem_q;
            else if (sclk_rise) tb_sr <= {tb_sr[6:0], mosi};
        end
    end

    // reference model and scoreboard
    logic [7:0]  ref_mem [0:127];
    logic [14:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int t = 0;
    int addr_we_cnt, addr_we_t, sr_we_cnt, sr_we_t, bufe_first_t;
    int dm_we_cnt, dm_we_t, done_cnt, done_t, bufe_rises, last_rise_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic clear_log();
        addr_we_cnt = 0; addr_we_t = -1; sr_we_cnt = 0; sr_we_t = -1; bufe_first_t = -1;
        dm_we_cnt = 0; dm_we_t = -1; done_cnt = 0; done_t = -1; bufe_rises = 0;
    endtask

    task automatic tick();
        logic [14:0] e;
        @(negedge clk);
        t++;
        if (addr_we) begin addr_we_cnt++; addr_we_t = t; end
        if (sr_we) begin sr_we_cnt++; sr_we_t = t; end
        if (miso_bufe && bufe_first_t < 0) bufe_first_t = t;
        if (txn_done) begin done_cnt++; done_t = t; end
        if (dm_we) begin
            dm_we_cnt++;
            dm_we_t = t;
            if (exp_q.size() == 0) begin
                chk("dm_we_unexpected", 32'(dm_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("dm_we_addr", 32'(dm_addr), 32'(e[14:8]));
                chk("dm_we_data", 32'(sr_data), 32'(e[7:0]));
            end
        end
    endtask

    task automatic spi_bit(input logic b, output logic m);
        sclk_rise = 1'b0;
        repeat (4) tick();
        mosi = b;
        m = tb_sr[7];
        if (miso_bufe) bufe_rises++;
        sclk_rise = 1'b1;
        last_rise_t = t;
        tick();
        sclk_rise = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] rd);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(b[i], m);
            rd[i] = m;
        end
    endtask

    task automatic cs_start();
        cs_cond = 1'b0;
        repeat (2) tick();
    endtask

    task automatic cs_end();
        cs_cond = 1'b1;
        tick();
        chk("cs_high_idle", 32'(state_dbg), 32'd0);
        repeat (2) tick();
    endtask

    task automatic do_read(input logic [6:0] a);
        logic [7:0] rd;
        int ra;
        clear_log();
        cs_start();
        spi_byte({a, 1'b1}, rd);
        ra = last_rise_t;
        bufe_rises = 0;
        spi_byte(8'h00, rd);
        chk("rd_addr_we_cnt", 32'(addr_we_cnt), 32'd1);
        chk("rd_addr_we_lat", 32'(addr_we_t), 32'(ra + 1));
        chk("rd_sr_we_lat", 32'(sr_we_t), 32'(ra + 3));
        chk("rd_sr_we_cnt", 32'(sr_we_cnt), 32'd1);
        chk("rd_bufe_first", 32'(bufe_first_t), 32'(ra + 4));
        chk("rd_bufe_rises", 32'(bufe_rises), 32'd8);
        chk("rd_data", 32'(rd), 32'(ref_mem[a]));
        chk("rd_done_cnt", 32'(done_cnt), 32'd1);
        chk("rd_done_lat", 32'(done_t), 32'(last_rise_t + 1));
`ifdef SPI_BURST_EN
        chk("rd_state_after", 32'(state_dbg), 32'd3);
        chk("rd_dm_addr", 32'(dm_addr), 32'(7'(a + 7'd1)));
`else
        chk("rd_state_after", 32'(state_dbg), 32'd7);
        chk("rd_dm_addr", 32'(dm_addr), 32'(a));
`endif
        cs_end();
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        logic [7:0] rd;
        int ra;
        clear_log();
        exp_q.push_back({a, d});
        ref_mem[a] = d;
        cs_start();
        spi_byte({a, 1'b0}, rd);
        ra = last_rise_t;
        spi_byte(d, rd);
        chk("wr_addr_we_lat", 32'(addr_we_t), 32'(ra + 1));
        chk("wr_dm_we_cnt", 32'(dm_we_cnt), 32'd1);
        chk("wr_dm_we_lat", 32'(dm_we_t), 32'(last_rise_t + 1));
        chk("wr_done_cnt", 32'(done_cnt), 32'd1);
        cs_end();
    endtask

    initial begin
        logic [7:0] rd;
        logic       m;
        logic [6:0] a;
        logic [7:0] d;

        reset = 1'b1; cs_cond = 1'b1; sclk_rise = 1'b0; mosi = 1'b0; mem_init = 1'b1;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        clear_log();
        repeat (3) tick();
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_dm_addr", 32'(dm_addr), 32'd0);
        chk("rst_pulses", 32'({sr_we, addr_we, dm_we, miso_bufe, txn_done}), 32'd0);
        reset = 1'b0; mem_init = 1'b0;
        repeat (3) tick();

        do_read(7'h05);
        do_write(7'h0A, 8'h3C);
        do_read(7'h0A);

        for (int k = 0; k < 6; k++) begin
            a = 7'($urandom_range(0, 127));
            d = 8'($urandom_range(0, 255));
            do_write(a, d);
            do_read(7'($urandom_range(0, 127)));
            do_read(a);
        end

        // CS raised after 5 data bits of a write
        clear_log();
        cs_start();
        spi_byte({7'h21, 1'b0}, rd);
        for (int i = 0; i < 5; i++) spi_bit(1'($urandom_range(0, 1)), m);
        repeat (2) tick();
        cs_cond = 1'b1;
        tick();
        chk("abort5_state", 32'(state_dbg), 32'd0);
        repeat (20) tick();
        chk("abort5_dm_we", 32'(dm_we_cnt), 32'd0);
        chk("abort5_done", 32'(done_cnt), 32'd0);

        // CS rise on the same cycle as the 8th data rise
        clear_log();
        cs_start();
        spi_byte({7'h22, 1'b0}, rd);
        for (int i = 0; i < 7; i++) spi_bit(1'($urandom_range(0, 1)), m);
        repeat (4) tick();
        mosi = 1'b1;
        sclk_rise = 1'b1;
        cs_cond = 1'b1;
        tick();
        sclk_rise = 1'b0;
        chk("abort8_state", 32'(state_dbg), 32'd0);
        repeat (10) tick();
        chk("abort8_dm_we", 32'(dm_we_cnt), 32'd0);
        do_read(7'h22);

        // reset during READ_SHIFT with CS held low
        clear_log();
        cs_start();
        spi_byte({7'h05, 1'b1}, rd);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, m);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_state", 32'(state_dbg), 32'd0);
        chk("mid_rst_dm_addr", 32'(dm_addr), 32'd0);
        chk("mid_rst_pulses", 32'({sr_we, addr_we, dm_we, miso_bufe, txn_done}), 32'd0);
        clear_log();
        for (int i = 0; i < 12; i++) spi_bit(1'($urandom_range(0, 1)), m);
        chk("mid_rst_no_start", 32'(addr_we_cnt), 32'd0);
        chk("mid_rst_hold_idle", 32'(state_dbg), 32'd0);
        cs_cond = 1'b1;
        repeat (3) tick();
        do_read(7'h05);

`ifdef SPI_BURST_EN
        clear_log();
        d = 8'($urandom_range(0, 255));
        exp_q.push_back({7'h7F, d});
        ref_mem[7'h7F] = d;
        cs_start();
        spi_byte(8'hFE, rd);
        spi_byte(d, rd);
        d = 8'($urandom_range(0, 255));
        exp_q.push_back({7'h00, d});
        ref_mem[7'h00] = d;
        spi_byte(d, rd);
        chk("burst_dm_we_cnt", 32'(dm_we_cnt), 32'd2);
        chk("burst_done_cnt", 32'(done_cnt), 32'd2);
        cs_end();
        do_read(7'h00);
`endif

        repeat (5) tick();
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
